// File: rtl/display_capture.sv
// display_capture: qualifies a 7-segment pattern sampled from a target
// FPGA, decodes it to a hex digit and queues each newly accepted digit
// in a small FIFO for a ready/valid consumer.
// Optional feature macro: DISPLAY_CAPTURE_ERR_EN. When it is defined, an
// undecodable, non-blank pattern queues an error entry. When it is not
// defined, such a pattern is silently absorbed and out_err is held at 0.
module display_capture #(
  parameter int STABLE_CYCLES = 4,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [6:0] io_display,
  output logic [3:0] out_digit,
  output logic       out_err,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [3:0]  STABLE_C = 4'(STABLE_CYCLES);
  localparam logic [AW:0] DEPTH_C  = (AW + 1)'(FIFO_DEPTH);

`ifdef DISPLAY_CAPTURE_ERR_EN
  localparam int EW = 5;  // {err, digit}
`else
  localparam int EW = 4;  // digit only
`endif

  // Sampling and qualification state
  logic [6:0]    s_q, s_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [6:0]    last_q, last_d;

  // FIFO state; kept in registers so the head entry is visible
  // without a read cycle.
  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          ovf_q, ovf_d;

  logic [3:0]    dec_digit;
  logic          dec_ok;
  logic          accept;
  logic          push_req;
  logic [EW-1:0] push_data;
  logic          full;
  logic          pop;
  logic          push_ok;
  logic [EW-1:0] head;

  // Segment decoder: maps the sampled pattern to a hex digit.
  always_comb begin
    dec_ok    = 1'b1;
    dec_digit = 4'h0;
    case (s_q)
      7'h3F: dec_digit = 4'h0;
      7'h06: dec_digit = 4'h1;
      7'h5B: dec_digit = 4'h2;
      7'h4F: dec_digit = 4'h3;
      7'h66: dec_digit = 4'h4;
      7'h6D: dec_digit = 4'h5;
      7'h7D: dec_digit = 4'h6;
      7'h07: dec_digit = 4'h7;
      7'h7F: dec_digit = 4'h8;
      7'h6F: dec_digit = 4'h9;
      7'h77: dec_digit = 4'hA;
      7'h7C: dec_digit = 4'hB;
      7'h39: dec_digit = 4'hC;
      7'h5E: dec_digit = 4'hD;
      7'h79: dec_digit = 4'hE;
      7'h71: dec_digit = 4'hF;
      default: dec_ok = 1'b0;
    endcase
  end

  // A pattern is accepted once it has been held long enough and differs
  // from the last accepted pattern. Because last_code is updated on the
  // same edge, accept stays high for only one cycle.
  assign accept = (cnt_q == STABLE_C) && (s_q != last_q);

`ifdef DISPLAY_CAPTURE_ERR_EN
  // Blank never queues. Any other pattern queues a digit or an error.
  assign push_req  = accept && (s_q != 7'h00);
  assign push_data = dec_ok ? {1'b0, dec_digit} : {1'b1, 4'h0};
`else
  // Blank (00) is not in the decode table, so only real digits queue.
  assign push_req  = accept && dec_ok;
  assign push_data = dec_digit;
`endif

  assign full      = (count_q == DEPTH_C);
  assign out_valid = (count_q != '0);
  assign pop       = out_valid && out_ready;
  // A full FIFO can still take a push if the head leaves on the same edge.
  assign push_ok   = push_req && (!full || pop);
  assign head      = mem[rd_ptr_q];

  assign out_digit = out_valid ? head[3:0] : 4'h0;
`ifdef DISPLAY_CAPTURE_ERR_EN
  assign out_err   = out_valid & head[4];
`else
  assign out_err   = 1'b0;
`endif
  assign overflow  = ovf_q;

  // Next-state logic for the sampler, the stability counter and the FIFO
  // bookkeeping.
  always_comb begin
    s_d = io_display;
    if (io_display != s_q) begin
      cnt_d = 4'd1;
    end else if (cnt_q == STABLE_C) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + 4'd1;
    end

    last_d   = accept ? s_q : last_q;

    wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop     ? rd_ptr_q + AW'(1) : rd_ptr_q;

    count_d = count_q;
    case ({push_ok, pop})
      2'b10:   count_d = count_q + (AW + 1)'(1);
      2'b01:   count_d = count_q - (AW + 1)'(1);
      default: count_d = count_q;
    endcase

    ovf_d = ovf_q | (push_req && full && !pop);
  end

  // State registers. The synchronous active-low reset overrides every
  // concurrent push, pop and accept.
  always_ff @(posedge clock) begin
    if (!reset) begin
      s_q      <= 7'h00;
      cnt_q    <= 4'd0;
      last_q   <= 7'h00;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      s_q      <= s_d;
      cnt_q    <= cnt_d;
      last_q   <= last_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // FIFO storage write. Contents need no reset because the pointers
  // define which entries are valid.
  always_ff @(posedge clock) begin
    if (reset && push_ok) begin
      mem[wr_ptr_q] <= push_data;
    end
  end

endmodule

// File: tb/tb_display_capture.sv
// tb_display_capture: directed scenarios followed by randomized patterns,
// compared every cycle against a queue-based reference model.
// Honors DISPLAY_CAPTURE_ERR_EN in the same way as the design.
module tb_display_capture;

  localparam int STABLE = 4;
  localparam int DEPTH  = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [6:0] io_display = 7'h00;
  logic       out_ready = 1'b0;
  logic [3:0] out_digit;
  logic       out_err;
  logic       out_valid;
  logic       overflow;

  int checks = 0;
  int errors = 0;

  logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Reference model state
  logic [6:0] m_s    = 7'h00;
  logic [6:0] m_last = 7'h00;
  int         m_run  = 0;
  logic [4:0] m_fifo [$];
  logic       m_ovf  = 1'b0;

  int dut_pops [$];

  display_capture #(.STABLE_CYCLES(STABLE), .FIFO_DEPTH(DEPTH)) dut (
    .clock      (clock),
    .reset      (reset),
    .io_display (io_display),
    .out_digit  (out_digit),
    .out_err    (out_err),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .overflow   (overflow)
  );

  always #5 clock = ~clock;

  function automatic int decode(input logic [6:0] c);
    for (int i = 0; i < 16; i++) begin
      if (seg_tab[i] == c) return i;
    end
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock edge of the reference model, using the inputs that the
  // design sees on that edge.
  function automatic void model_edge();
    bit         pop_now;
    bit         acc;
    bit         have;
    logic [4:0] ent;
    int         d;
    if (!reset) begin
      m_s    = 7'h00;
      m_last = 7'h00;
      m_run  = 0;
      m_fifo.delete();
      m_ovf  = 1'b0;
      return;
    end
    pop_now = (m_fifo.size() != 0) && out_ready;
    acc     = (m_run >= STABLE) && (m_s != m_last);
    have    = 1'b0;
    ent     = 5'h00;
    if (acc) begin
      m_last = m_s;
      d = decode(m_s);
      if (d >= 0) begin
        have = 1'b1;
        ent  = {1'b0, 4'(d)};
      end
`ifdef DISPLAY_CAPTURE_ERR_EN
      else if (m_s != 7'h00) begin
        have = 1'b1;
        ent  = 5'b10000;
      end
`endif
    end
    if (pop_now) void'(m_fifo.pop_front());
    if (have) begin
      if (m_fifo.size() < DEPTH) m_fifo.push_back(ent);
      else m_ovf = 1'b1;
    end
    if (io_display != m_s) m_run = 1;
    else m_run++;
    m_s = io_display;
  endfunction

  task automatic check_outputs();
    chk("valid", 32'(out_valid), 32'(m_fifo.size() != 0));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    if (m_fifo.size() != 0) begin
      chk("digit", 32'(out_digit), 32'(m_fifo[0][3:0]));
      chk("err", 32'(out_err), 32'(m_fifo[0][4]));
    end
  endtask

  task automatic step();
    if (out_valid === 1'b1 && out_ready && reset) dut_pops.push_back(int'(out_digit));
    @(posedge clock);
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic hold(input logic [6:0] c, input int n);
    io_display = c;
    repeat (n) step();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
    dut_pops.delete();
  endtask

  // Count edges until out_valid rises, bounded.
  task automatic wait_valid(input string tag, input int expect_edges);
    int n;
    n = 0;
    while (out_valid !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk(tag, 32'(n), 32'(expect_edges));
  endtask

  initial begin
    int         ready_pct;
    int         total;
    int         len;
    int         r;
    logic [6:0] code;

    // Reset for two edges with 06 presented, then release.
    reset = 1'b0; io_display = 7'h06; out_ready = 1'b0;
    step();
    step();
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_digit", 32'(out_digit), 32'd0);
    chk("rst_err", 32'(out_err), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    reset = 1'b1;
    wait_valid("latency_06", STABLE + 1);
    chk("digit_06", 32'(out_digit), 32'd1);
    chk("err_06", 32'(out_err), 32'd0);

    // Glitch to 5B and back to 0 yields a single entry.
    io_display = 7'h00;
    do_reset();
    out_ready = 1'b1;
    hold(7'h3F, 10);
    hold(7'h5B, 2);
    hold(7'h3F, 10);
    chk("glitch_count", 32'(dut_pops.size()), 32'd1);
    if (dut_pops.size() >= 1) chk("glitch_digit", 32'(dut_pops[0]), 32'd0);

    // Five digits with no consumer: four are held, the fifth overflows.
    do_reset();
    out_ready = 1'b0;
    hold(7'h06, 6);
    hold(7'h5B, 6);
    hold(7'h4F, 6);
    hold(7'h66, 6);
    hold(7'h6D, 6);
    chk("full_overflow", 32'(overflow), 32'd1);
    chk("full_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    dut_pops.delete();
    hold(7'h6D, 8);
    chk("drain_count", 32'(dut_pops.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < dut_pops.size()) chk("drain_order", 32'(dut_pops[i]), 32'(i + 1));
    end

    // Blank, then 8, then blank: only the 8 is queued.
    do_reset();
    out_ready = 1'b1;
    hold(7'h00, 8);
    hold(7'h7F, 8);
    hold(7'h00, 8);
    chk("blank_count", 32'(dut_pops.size()), 32'd1);
    if (dut_pops.size() >= 1) chk("blank_digit", 32'(dut_pops[0]), 32'd8);

    // Undecodable pattern 01.
    do_reset();
    out_ready = 1'b0;
    hold(7'h01, 8);
`ifdef DISPLAY_CAPTURE_ERR_EN
    chk("inv_valid", 32'(out_valid), 32'd1);
    chk("inv_err", 32'(out_err), 32'd1);
    chk("inv_digit", 32'(out_digit), 32'd0);
`else
    chk("inv_valid", 32'(out_valid), 32'd0);
`endif
    out_ready = 1'b1;
    step();
    step();

    // Reset in the middle of qualifying 4F.
    io_display = 7'h00;
    do_reset();
    out_ready = 1'b0;
    io_display = 7'h4F;
    step();
    step();
    reset = 1'b0;
    step();
    reset = 1'b1;
    wait_valid("latency_midsettle", STABLE + 1);
    chk("midsettle_digit", 32'(out_digit), 32'd3);

    // Randomized patterns, glitches, consumer stalls and occasional resets.
    do_reset();
    total = 0;
    code  = 7'h00;
    while (total < 3000) begin
      ready_pct = (total < 1500) ? 75 : 25;
      r = int'($urandom_range(0, 9));
      if (r <= 5)      code = seg_tab[$urandom_range(0, 15)];
      else if (r == 6) code = 7'h00;
      else if (r == 7) code = 7'($urandom);
      len = int'($urandom_range(1, 7));
      io_display = code;
      for (int k = 0; k < len; k++) begin
        out_ready = (int'($urandom_range(0, 99)) < ready_pct);
        reset     = ($urandom_range(0, 199) != 0);
        step();
        total++;
      end
    end
    reset = 1'b1;
    out_ready = 1'b1;
    repeat (10) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/display_capture.md
DISPLAY_CAPTURE -- requirements
Module: display_capture

Interface
REQ-001 The module SHALL have parameter STABLE_CYCLES, default 4 (legal 2..15), the number of consecutive identical samples needed before a segment code is accepted.
REQ-002 The module SHALL have parameter FIFO_DEPTH, default 4 (power of two, 2..16), the number of entries in the output FIFO.
REQ-003 The module SHALL have port clock, input, 1 bit, the single system clock; all state SHALL update on its rising edge.
REQ-004 The module SHALL have port reset, input, 1 bit, a synchronous active-low reset.
REQ-005 The module SHALL have port io_display, input, 7 bits, the segment pattern driven by the FPGA device; bit0=a through bit6=g, and 1 means the segment is lit.
REQ-006 The module SHALL have port out_digit, output, 4 bits, the decoded hex digit at the FIFO head.
REQ-007 The module SHALL have port out_err, output, 1 bit, set when the FIFO head came from an undecodable pattern.
REQ-008 The module SHALL have port out_valid, output, 1 bit, high when the FIFO is non-empty.
REQ-009 The module SHALL have port out_ready, input, 1 bit, the consumer accept; a pop SHALL occur on an edge where out_valid and out_ready are both high.
REQ-010 The module SHALL have port overflow, output, 1 bit, a sticky flag meaning an accepted code was dropped because the FIFO was full.

Function
REQ-011 io_display SHALL be registered into a sample register s on every edge, and no combinational path SHALL exist from io_display to any output.
REQ-012 The stability counter cnt SHALL be loaded with 1 when the new s differs from the previous s; otherwise it SHALL increment and saturate at STABLE_CYCLES.
REQ-013 An accept event SHALL fire for exactly one cycle when cnt == STABLE_CYCLES and s != last_code; on that event, last_code SHALL be loaded with s.
REQ-014 Decoding SHALL use these codes: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71 (hex).
REQ-015 An accepted code of 00 (blank) SHALL update last_code without pushing an entry.
REQ-016 An accepted decodable code SHALL push {digit, err=0} on the edge after the accept event.
REQ-017 An accepted code that is neither decodable nor blank SHALL be handled as defined in Configuration.
REQ-018 Latency: with the FIFO empty, out_valid SHALL rise after edge STABLE_CYCLES+1, where edge 1 is the first edge that samples the new pattern.
REQ-019 A pattern held for fewer than STABLE_CYCLES consecutive samples (a glitch) SHALL produce no push.
REQ-020 A pattern that returns to last_code after a glitch SHALL produce no push.
REQ-021 When a push and a pop occur on the same edge with the FIFO full, both SHALL succeed and the FIFO SHALL remain full.
REQ-022 When a push and a pop occur on the same edge with the FIFO empty, the push SHALL be stored and no pop SHALL occur.
REQ-023 A push while the FIFO is full with no pop SHALL be dropped, set overflow, and leave the FIFO contents unchanged.
REQ-024 The FIFO read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-025 out_digit and out_err SHALL remain stable while out_valid is high and out_ready is low.

Reset
REQ-026 On an edge with reset low, the following SHALL be cleared: s=00, cnt=0, last_code=00, FIFO empty, out_valid=0, out_digit=0, out_err=0, overflow=0.
REQ-027 Reset SHALL take priority over any concurrent push, pop, or accept.
REQ-028 Reset asserted mid-settle SHALL discard the partial count, and the pattern SHALL then be re-qualified from cnt=0.

Configuration
REQ-029 With macro DISPLAY_CAPTURE_ERR_EN defined, an accepted invalid code SHALL push {digit=0, err=1}.
REQ-030 With DISPLAY_CAPTURE_ERR_EN undefined, an accepted invalid code SHALL update last_code without pushing, and out_err SHALL be tied to 0.

Verification
REQ-031 Scenario: reset low for 2 edges, then io_display=06 held -> out_valid high after edge 5, out_digit=1, out_err=0.
REQ-032 Scenario: 3F held for 10 cycles, then 5B for 2 cycles, then back to 3F, with out_ready=1 -> exactly one entry (digit 0) produced.
REQ-033 Scenario: out_ready=0, then 5 distinct stable digits 1,2,3,4,5 -> FIFO holds 1,2,3,4, overflow=1; then drain -> pops 1,2,3,4 in order.
REQ-034 Scenario: io_display=00 stable, then 7F stable -> only digit 8 pushed; then 00 stable -> no push.
REQ-035 Scenario: io_display=01 stable -> with DISPLAY_CAPTURE_ERR_EN, one entry with out_err=1, digit=0; without the macro, no entry.
REQ-036 Scenario: reset low at cnt=2 while 4F is settling, then released with 4F still held -> digit 3 pushed STABLE_CYCLES+1 edges after release.
